alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_if.sv | 32 +++
 rtl/alu_arb.sv | 69 ++++++
 tb/tb_alu_arb.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// alu_arb_if: requester, shared-alu and response signals of the alu arbiter
interface alu_arb_if;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_aluc;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_aluc;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_aluc;
   logic        alu_zero, alu_carry, alu_negative, alu_overflow;
   logic [1:0]  resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_zero, resp_carry, resp_negative, resp_overflow;
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_aluc, req1_valid, req1_a, req1_b, req1_aluc,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_aluc,
      input  alu_result, alu_zero, alu_carry, alu_negative, alu_overflow,
      output resp_valid, resp_result, resp_zero, resp_carry, resp_negative, resp_overflow,
      input  resp_ready
   );
   modport master (
      output req0_valid, req0_a, req0_b, req0_aluc, req1_valid, req1_a, req1_b, req1_aluc,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_aluc,
      output alu_result, alu_zero, alu_carry, alu_negative, alu_overflow,
      input  resp_valid, resp_result, resp_zero, resp_carry, resp_negative, resp_overflow,
      output resp_ready
   );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one alu between two requesters
module alu_arb (
   input  logic            clk,
   input  logic            rst,
   alu_arb_if.slave        bus,
   output logic            busy,
   output logic [15:0]     op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t      state, state_nxt;
   logic        last, idx, win0, win1, hs;
   logic [31:0] a, b, res;
   logic [3:0]  aluc;
   logic        zero, carry, neg, ovf;
   always_comb begin
      // last=1 means requester 1 was served last, so requester 0 wins a tie
      win0 = bus.req0_valid & (~bus.req1_valid | last);
      win1 = bus.req1_valid & (~bus.req0_valid | ~last);
      bus.req0_ready = (state == IDLE) & win0 & ~rst;
      bus.req1_ready = (state == IDLE) & win1 & ~rst;
      hs = bus.req0_ready | bus.req1_ready;
      state_nxt = (state == IDLE) ? (hs ? EXEC : IDLE) :
                  (state == EXEC) ? RESP :
                  (bus.resp_ready ? IDLE : RESP);
   end
   assign busy              = state != IDLE;
   assign bus.resp_valid    = (state == RESP) ? {idx, ~idx} : 2'b00;
   assign bus.alu_a         = a;
   assign bus.alu_b         = b;
   assign bus.alu_aluc      = aluc;
   assign bus.resp_result   = res;
   assign bus.resp_zero     = zero;
   assign bus.resp_carry    = carry;
   assign bus.resp_negative = neg;
   assign bus.resp_overflow = ovf;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         idx      <= 1'b0;
         a        <= '0;
         b        <= '0;
         aluc     <= '0;
         res      <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         neg      <= 1'b0;
         ovf      <= 1'b0;
         op_count <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            a    <= bus.req1_ready ? bus.req1_a : bus.req0_a;
            b    <= bus.req1_ready ? bus.req1_b : bus.req0_b;
            aluc <= bus.req1_ready ? bus.req1_aluc : bus.req0_aluc;
            idx  <= bus.req1_ready;
            last <= bus.req1_ready;
         end
         if (state == EXEC) begin
            res   <= bus.alu_result;
            zero  <= bus.alu_zero;
            carry <= bus.alu_carry;
            neg   <= bus.alu_negative;
            ovf   <= bus.alu_overflow;
         end
         if (state == RESP && bus.resp_ready) op_count <= op_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: table-driven and randomized checks of alu_arb against a transaction model
module tb_alu_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] op_count;
   int          n_chk = 0;
   int          n_fail = 0;
   int          m_last;
   logic [15:0] m_count;
   alu_arb_if bus ();
   alu_arb dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .op_count(op_count));
   always #5 clk = ~clk;
   // alu stub: sum with zero flag only
   assign bus.alu_result   = bus.alu_a + bus.alu_b;
   assign bus.alu_zero     = (bus.alu_a + bus.alu_b) == 32'd0;
   assign bus.alu_carry    = 1'b0;
   assign bus.alu_negative = 1'b0;
   assign bus.alu_overflow = 1'b0;
   typedef struct {
      logic        v0, v1;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  exp_rv;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.req0_valid = 0; bus.req1_valid = 0;
      bus.req0_a = 0; bus.req0_b = 0; bus.req0_aluc = 0;
      bus.req1_a = 0; bus.req1_b = 0; bus.req1_aluc = 0;
      bus.resp_ready = 0;
   endtask
   task automatic do_reset();
      bus.req0_valid = 1; bus.req1_valid = 1;
      rst = 1;
      #1;
      chk("ready_in_reset", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
      tick();
      rst = 0;
      idle_inputs();
      m_last = 1;
      m_count = 0;
      #1;
      chk("rst_resp_valid", {30'd0, bus.resp_valid}, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_aluc", {28'd0, bus.alu_aluc}, 0);
      chk("rst_resp_result", bus.resp_result, 0);
      chk("rst_resp_flags", {28'd0, bus.resp_zero, bus.resp_carry, bus.resp_negative, bus.resp_overflow}, 0);
      chk("rst_op_count", {16'd0, op_count}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
   endtask
   // One complete transaction from IDLE, checking protocol against the model.
   task automatic do_op(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c0,
                        input logic [3:0] c1, input int stall,
                        output logic [1:0] rv, output logic [31:0] res, output logic z);
      int w;
      logic [31:0] ea, eb;
      w = (v0 && v1) ? (m_last == 0 ? 1 : 0) : (v1 ? 1 : 0);
      ea = w == 1 ? a1 : a0;
      eb = w == 1 ? b1 : b0;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_aluc = c0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_aluc = c1;
      bus.resp_ready = 0;
      #1;
      chk("idle_ready", {30'd0, bus.req1_ready, bus.req0_ready}, w == 1 ? 2 : 1);
      chk("idle_busy", {31'd0, busy}, 0);
      tick();
      bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_aluc = 4'($urandom);
      bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_aluc = 4'($urandom);
      #1;
      chk("exec_busy", {31'd0, busy}, 1);
      chk("exec_resp_valid", {30'd0, bus.resp_valid}, 0);
      chk("exec_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
      chk("exec_alu_a", bus.alu_a, ea);
      chk("exec_alu_b", bus.alu_b, eb);
      chk("exec_alu_aluc", {28'd0, bus.alu_aluc}, {28'd0, w == 1 ? c1 : c0});
      tick();
      rv = bus.resp_valid;
      res = bus.resp_result;
      z = bus.resp_zero;
      chk("resp_ready_low", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("hold_resp_valid", {30'd0, bus.resp_valid}, {30'd0, rv});
         chk("hold_resp_result", bus.resp_result, res);
         chk("hold_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
         chk("hold_busy", {31'd0, busy}, 1);
      end
      bus.resp_ready = 1;
      tick();
      idle_inputs();
      m_last = w;
      m_count = m_count + 16'd1;
      #1;
      chk("done_op_count", {16'd0, op_count}, {16'd0, m_count});
      chk("done_resp_valid", {30'd0, bus.resp_valid}, 0);
      chk("done_busy", {31'd0, busy}, 0);
   endtask
   initial begin
      vec_t vecs[6];
      logic [1:0]  rv;
      logic [31:0] res, a0, b0, a1, b1, er;
      logic        z;
      int          r, w;
      vecs[0] = '{1, 1, 1, 1, 5, 5, 2'b01, 2, 0};
      vecs[1] = '{1, 1, 1, 1, 5, 5, 2'b10, 10, 0};
      vecs[2] = '{1, 1, 1, 1, 5, 5, 2'b01, 2, 0};
      vecs[3] = '{0, 1, 0, 0, 0, 0, 2'b10, 0, 1};
      vecs[4] = '{1, 0, 32, 64, 0, 0, 2'b01, 96, 0};
      vecs[5] = '{1, 1, 1, 1, 5, 5, 2'b10, 10, 0};
      idle_inputs();
      rst = 1;
      tick();
      do_reset();
      do_op(1, 0, 32, 64, 0, 0, 4'd0, 4'd0, 0, rv, res, z);
      chk("single_rv", {30'd0, rv}, 1);
      chk("single_res", res, 96);
      chk("single_zero", {31'd0, z}, 0);
      chk("single_count", {16'd0, op_count}, 1);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
               4'(i), 4'(i + 8), i % 3, rv, res, z);
         chk($sformatf("vec%0d_rv", i), {30'd0, rv}, {30'd0, vecs[i].exp_rv});
         chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
         chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
      end
      do_op(1, 1, 3, 4, 6, 7, 4'd2, 4'd3, 5, rv, res, z);
      chk("bp_rv", {30'd0, rv}, 1);
      chk("bp_res", res, 7);
      bus.req0_valid = 1; bus.req0_a = 7; bus.req0_b = 9;
      tick();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_resp_valid", {30'd0, bus.resp_valid}, 0);
      chk("abort_op_count", {16'd0, op_count}, 0);
      chk("abort_alu_a", bus.alu_a, 0);
      bus.resp_ready = 1;
      tick();
      chk("abort_no_resp", {30'd0, bus.resp_valid}, 0);
      bus.resp_ready = 0;
      m_last = 1;
      m_count = 0;
      do_op(1, 1, 2, 2, 9, 9, 4'd1, 4'd1, 0, rv, res, z);
      chk("post_abort_rv", {30'd0, rv}, 1);
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(1, 3);
         a0 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         b0 = ($urandom_range(0, 5) == 0) ? -a0 : $urandom;
         a1 = $urandom;
         b1 = ($urandom_range(0, 5) == 0) ? -a1 : $urandom;
         w = (r == 3) ? (m_last == 0 ? 1 : 0) : (r == 2 ? 1 : 0);
         er = w == 1 ? a1 + b1 : a0 + b0;
         do_op(r[0], r[1], a0, b0, a1, b1, 4'($urandom), 4'($urandom), $urandom_range(0, 3), rv, res, z);
         chk("rand_rv", {30'd0, rv}, w == 1 ? 2 : 1);
         chk("rand_res", res, er);
         chk("rand_zero", {31'd0, z}, {31'd0, er == 0});
      end
      force dut.op_count = 16'hFFFF;
      tick();
      release dut.op_count;
      m_count = 16'hFFFF;
      tick();
      chk("preload_count", {16'd0, op_count}, 32'hFFFF);
      do_op(0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 1, rv, res, z);
      chk("wrap_count", {16'd0, op_count}, 0);
      chk("wrap_zero", {31'd0, z}, 1);
      chk("wrap_rv", {30'd0, rv}, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
